// File: rtl/lcd_bus_writer_pkg.sv
// lcd_pkg
// Shared definitions for the LCD bus writer: RS encoding, the request
// entry layout held in the FIFO, bus FSM state encoding and the default
// 20 MHz timing constants.
//   RS_CMD / RS_DATA  : values driven on lcd_rs for command / data writes
//   lcd_req_t         : 9-bit FIFO entry {rs, byte}
//   ST_*              : bus FSM states
//   T_*_DEF           : default cycle counts for the 20 MHz panel clock
package lcd_pkg;

  localparam logic RS_CMD  = 1'b0;
  localparam logic RS_DATA = 1'b1;

  typedef struct packed {
    logic       rs;
    logic [7:0] val;
  } lcd_req_t;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SETUP = 3'd1;
  localparam logic [2:0] ST_PULSE = 3'd2;
  localparam logic [2:0] ST_HOLD  = 3'd3;
  localparam logic [2:0] ST_EXEC  = 3'd4;

  localparam int T_SETUP_DEF = 2;
  localparam int T_PULSE_DEF = 10;
  localparam int T_HOLD_DEF  = 2;
  localparam int T_EXEC_DEF  = 1440;

  // Largest of the four phase lengths; sizes the shared phase counter.
  function automatic int max_of4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/lcd_bus_writer_if.sv
// lcd_bus_writer_if
// Bundles the upstream request strobes and the LCD panel pins.
//   dr/direc   : command request level and byte
//   wr/dbi     : data request level and byte
//   lcd_rs/rw/e/db : 6800-style panel bus
//   busy/overflow  : status back to the requester
// Modport slave is the writer's view, master is the requester/panel side.
interface lcd_bus_writer_if;
  logic       dr;
  logic [7:0] direc;
  logic       wr;
  logic [7:0] dbi;
  logic       lcd_rs;
  logic       lcd_rw;
  logic       lcd_e;
  logic [7:0] lcd_db;
  logic       busy;
  logic       overflow;

  modport slave (
    input  dr, direc, wr, dbi,
    output lcd_rs, lcd_rw, lcd_e, lcd_db, busy, overflow
  );

  modport master (
    output dr, direc, wr, dbi,
    input  lcd_rs, lcd_rw, lcd_e, lcd_db, busy, overflow
  );
endinterface

// File: rtl/lcd_bus_writer_fifo.sv
// lcd_req_fifo
// Request FIFO of DEPTH 9-bit entries with two push ports written in the
// same cycle (cmd port first, data port second) and one pop port.
//   clk, rst            : clock, asynchronous active-low reset
//   push_cmd/cmd_entry  : first push port
//   push_data/data_entry: second push port
//   pop                 : remove head (ignored when empty)
//   head                : current head entry
//   empty / empty_next  : occupancy now / after this clock edge
//   drop                : a push request this cycle was rejected
module lcd_req_fifo
  import lcd_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     push_cmd,
  input  lcd_req_t cmd_entry,
  input  logic     push_data,
  input  lcd_req_t data_entry,
  input  logic     pop,
  output lcd_req_t head,
  output logic     empty,
  output logic     empty_next,
  output logic     drop
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  lcd_req_t      mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr_data;
  logic [CW-1:0] count;
  logic [CW-1:0] count_next;
  logic [CW-1:0] free;
  logic          pop_ok;
  logic          acc_cmd;
  logic          acc_data;

  // A same-cycle pop frees its slot before pushes are judged, so a full
  // FIFO being drained still accepts one push. The data entry needs a
  // slot beyond whatever the cmd entry took.
  always_comb begin
    pop_ok      = pop && (count != '0);
    free        = CW'(DEPTH) - count + CW'(pop_ok);
    acc_cmd     = push_cmd && (free != '0);
    acc_data    = push_data && (free > CW'(acc_cmd));
    wr_ptr_data = acc_cmd ? wr_ptr + AW'(1) : wr_ptr;
    drop        = (push_cmd && !acc_cmd) || (push_data && !acc_data);
    count_next  = count + CW'(acc_cmd) + CW'(acc_data) - CW'(pop_ok);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(acc_cmd) + AW'(acc_data);
      rd_ptr <= rd_ptr + AW'(pop_ok);
      count  <= count_next;
    end
  end

  // Storage needs no reset: the pointers decide what is valid.
  always_ff @(posedge clk) begin
    if (acc_cmd)  mem[wr_ptr]      <= cmd_entry;
    if (acc_data) mem[wr_ptr_data] <= data_entry;
  end

  assign head       = mem[rd_ptr];
  assign empty      = (count == '0);
  assign empty_next = (count_next == '0);

endmodule

// File: rtl/lcd_bus_writer.sv
// lcd_bus_writer
// Turns command/data request edges into timed 6800-style LCD write cycles,
// buffering requests in lcd_req_fifo so the requester never waits on the
// panel's execution time.
//   clk  : system clock (20 MHz)
//   rst  : asynchronous active-low reset
//   bus  : lcd_bus_writer_if.slave (requests in, panel pins and status out)
module lcd_bus_writer
  import lcd_pkg::*;
#(
  parameter int T_SETUP = T_SETUP_DEF,
  parameter int T_PULSE = T_PULSE_DEF,
  parameter int T_HOLD  = T_HOLD_DEF,
  parameter int T_EXEC  = T_EXEC_DEF,
  parameter int DEPTH   = 4
) (
  input logic clk,
  input logic rst,
  lcd_bus_writer_if.slave bus
);

  localparam int T_MAX = max_of4(T_SETUP, T_PULSE, T_HOLD, T_EXEC);
  localparam int CNT_W = (T_MAX > 1) ? $clog2(T_MAX) : 1;

  logic             dr_q;
  logic             wr_q;
  logic             cmd_edge;
  logic             data_edge;
  logic [2:0]       state;
  logic [2:0]       state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             pop;
  lcd_req_t         head;
  lcd_req_t         cmd_entry;
  lcd_req_t         data_entry;
  logic             fifo_empty;
  logic             fifo_empty_next;
  logic             drop;
  logic             rs_q;
  logic [7:0]       db_q;
  logic             e_q;
  logic             busy_q;
  logic             overflow_q;

  assign cmd_edge   = bus.dr & ~dr_q;
  assign data_edge  = bus.wr & ~wr_q;
  assign cmd_entry  = '{rs: RS_CMD,  val: bus.direc};
  assign data_entry = '{rs: RS_DATA, val: bus.dbi};
  assign pop        = (state == ST_IDLE) && !fifo_empty;

  lcd_req_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_cmd   (cmd_edge),
    .cmd_entry  (cmd_entry),
    .push_data  (data_edge),
    .data_entry (data_entry),
    .pop        (pop),
    .head       (head),
    .empty      (fifo_empty),
    .empty_next (fifo_empty_next),
    .drop       (drop)
  );

  // Each phase reloads the shared counter with its length minus one and
  // advances once the counter has run down to zero.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          state_nxt = ST_SETUP;
          cnt_nxt   = CNT_W'(T_SETUP - 1);
        end
      end
      ST_SETUP: begin
        if (cnt == '0) begin
          state_nxt = ST_PULSE;
          cnt_nxt   = CNT_W'(T_PULSE - 1);
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      ST_PULSE: begin
        if (cnt == '0) begin
          state_nxt = ST_HOLD;
          cnt_nxt   = CNT_W'(T_HOLD - 1);
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      ST_HOLD: begin
        if (cnt == '0) begin
          state_nxt = ST_EXEC;
          cnt_nxt   = CNT_W'(T_EXEC - 1);
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      ST_EXEC: begin
        if (cnt == '0) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // E and busy are registered from next-state values so they line up
  // exactly with the phase boundaries and never glitch.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dr_q       <= 1'b0;
      wr_q       <= 1'b0;
      state      <= ST_IDLE;
      cnt        <= '0;
      rs_q       <= RS_CMD;
      db_q       <= 8'h00;
      e_q        <= 1'b0;
      busy_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      dr_q       <= bus.dr;
      wr_q       <= bus.wr;
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      e_q        <= (state_nxt == ST_PULSE);
      busy_q     <= (state_nxt != ST_IDLE) || !fifo_empty_next;
      overflow_q <= overflow_q | drop;
      if (pop) begin
        rs_q <= head.rs;
        db_q <= head.val;
      end
    end
  end

  assign bus.lcd_rs   = rs_q;
  assign bus.lcd_rw   = 1'b0;
  assign bus.lcd_e    = e_q;
  assign bus.lcd_db   = db_q;
  assign bus.busy     = busy_q;
  assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_lcd_bus_writer.sv
// tb_lcd_bus_writer
// Drives directed and random request patterns into lcd_bus_writer and
// compares every cycle against a timeline model: a queue of pending
// entries plus "cycles since the current write started".
module tb_lcd_bus_writer;
  localparam int T_SETUP = 2;
  localparam int T_PULSE = 10;
  localparam int T_HOLD  = 2;
  localparam int T_EXEC  = 1440;
  localparam int DEPTH   = 4;
  localparam int TOTAL   = T_SETUP + T_PULSE + T_HOLD + T_EXEC;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  lcd_bus_writer_if bus_if ();

  lcd_bus_writer #(
    .T_SETUP(T_SETUP), .T_PULSE(T_PULSE), .T_HOLD(T_HOLD),
    .T_EXEC(T_EXEC), .DEPTH(DEPTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- reference model ----------------
  logic [8:0] mq[$];
  logic [8:0] mlog[$];
  bit         m_active = 0;
  int         m_k = 0;
  bit         m_rs = 0;
  logic [7:0] m_db = 8'h00;
  bit         m_ovf = 0;
  bit         m_drp = 0;
  bit         m_wrp = 0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mq.delete();
      m_active = 0;
      m_k = 0;
      m_rs = 0;
      m_db = 8'h00;
      m_ovf = 0;
      m_drp = 0;
      m_wrp = 0;
    end else begin
      bit was_idle;
      logic [8:0] e;
      was_idle = !m_active;
      if (m_active) begin
        m_k++;
        if (m_k == TOTAL) m_active = 0;
      end
      if (was_idle && mq.size() > 0) begin
        e = mq.pop_front();
        mlog.push_back(e);
        m_rs = e[8];
        m_db = e[7:0];
        m_active = 1;
        m_k = 0;
      end
      if (bus_if.dr && !m_drp) begin
        if (mq.size() < DEPTH) mq.push_back({1'b0, bus_if.direc});
        else m_ovf = 1;
      end
      if (bus_if.wr && !m_wrp) begin
        if (mq.size() < DEPTH) mq.push_back({1'b1, bus_if.dbi});
        else m_ovf = 1;
      end
      m_drp = bus_if.dr;
      m_wrp = bus_if.wr;
    end
  end

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // ---------------- per-cycle compare + write log ----------------
  logic [8:0] wlog[$];
  int         wtime[$];
  logic       prev_e = 1'b0;

  always @(negedge clk) begin
    bit exp_e;
    exp_e = m_active && (m_k >= T_SETUP) && (m_k < T_SETUP + T_PULSE);
    checkOutput("lcd_e",    16'(bus_if.lcd_e),    16'(exp_e));
    checkOutput("lcd_rs",   16'(bus_if.lcd_rs),   16'(m_rs));
    checkOutput("lcd_db",   16'(bus_if.lcd_db),   16'(m_db));
    checkOutput("lcd_rw",   16'(bus_if.lcd_rw),   16'h0);
    checkOutput("busy",     16'(bus_if.busy),     16'(m_active || mq.size() > 0));
    checkOutput("overflow", 16'(bus_if.overflow), 16'(m_ovf));
    if (bus_if.lcd_e && !prev_e) begin
      wlog.push_back({bus_if.lcd_rs, bus_if.lcd_db});
      wtime.push_back(cyc);
    end
    prev_e = bus_if.lcd_e;
  end

  // ---------------- stimulus helpers ----------------
  task automatic applyStimulus(input logic d, input logic w, input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    bus_if.dr = d;
    bus_if.wr = w;
    bus_if.direc = a;
    bus_if.dbi = b;
  endtask

  task automatic waitIdle();
    bit done;
    done = 0;
    for (int i = 0; i < 10000; i++) begin
      @(posedge clk);
      #1;
      if (!bus_if.busy) begin
        done = 1;
        break;
      end
    end
    checkOutput("idle_timeout", 16'(done), 16'h1);
  endtask

  int base;
  int delta;
  bit seen;

  initial begin
    bus_if.dr = 0;
    bus_if.wr = 0;
    bus_if.direc = 8'h00;
    bus_if.dbi = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_e",    16'(bus_if.lcd_e),    16'h0);
    checkOutput("rst_rs",   16'(bus_if.lcd_rs),   16'h0);
    checkOutput("rst_db",   16'(bus_if.lcd_db),   16'h0);
    checkOutput("rst_busy", 16'(bus_if.busy),     16'h0);
    checkOutput("rst_ovf",  16'(bus_if.overflow), 16'h0);
    @(negedge clk);
    rst = 1;

    // single command with exact timing
    applyStimulus(1, 0, 8'h90, 8'h00);
    @(posedge clk);
    applyStimulus(0, 0, 8'h90, 8'h00);
    @(posedge clk); #1;
    checkOutput("sc_rs_n1", 16'(bus_if.lcd_rs), 16'h0);
    checkOutput("sc_db_n1", 16'(bus_if.lcd_db), 16'h90);
    checkOutput("sc_e_n1",  16'(bus_if.lcd_e),  16'h0);
    checkOutput("sc_busy",  16'(bus_if.busy),   16'h1);
    @(posedge clk); #1;
    checkOutput("sc_e_n2", 16'(bus_if.lcd_e), 16'h0);
    @(posedge clk); #1;
    checkOutput("sc_e_n3", 16'(bus_if.lcd_e), 16'h1);
    repeat (9) @(posedge clk);
    #1;
    checkOutput("sc_e_n12", 16'(bus_if.lcd_e), 16'h1);
    @(posedge clk); #1;
    checkOutput("sc_e_n13", 16'(bus_if.lcd_e), 16'h0);
    repeat (1441) @(posedge clk);
    #1;
    checkOutput("sc_busy_n1454", 16'(bus_if.busy), 16'h1);
    @(posedge clk); #1;
    checkOutput("sc_busy_n1455", 16'(bus_if.busy), 16'h0);
    checkOutput("sc_nwrites", 16'(wlog.size()), 16'd1);
    if (wlog.size() == 1) checkOutput("sc_entry", 16'(wlog[0]), 16'h090);
    if (mlog.size() == 1) checkOutput("model_sc_entry", 16'(mlog[0]), 16'h090);

    // command then data two cycles later
    base = wlog.size();
    applyStimulus(1, 0, 8'h91, 8'h00);
    applyStimulus(0, 0, 8'h91, 8'h00);
    applyStimulus(0, 1, 8'h91, 8'hFF);
    applyStimulus(0, 0, 8'h91, 8'hFF);
    waitIdle();
    checkOutput("cd_nwrites", 16'(wlog.size() - base), 16'd2);
    if (wlog.size() == base + 2) begin
      checkOutput("cd_first",  16'(wlog[base]),     16'h091);
      checkOutput("cd_second", 16'(wlog[base + 1]), 16'h1FF);
      delta = wtime[base + 1] - wtime[base];
      checkOutput("cd_spacing", 16'(delta), 16'd1455);
    end

    // simultaneous edges
    base = wlog.size();
    applyStimulus(1, 1, 8'h92, 8'hFF);
    applyStimulus(0, 0, 8'h92, 8'hFF);
    waitIdle();
    checkOutput("sim_nwrites", 16'(wlog.size() - base), 16'd2);
    if (wlog.size() == base + 2) begin
      checkOutput("sim_first",  16'(wlog[base]),     16'h092);
      checkOutput("sim_second", 16'(wlog[base + 1]), 16'h1FF);
    end
    checkOutput("sim_ovf", 16'(bus_if.overflow), 16'h0);

    // overflow: six commands while the first write is executing
    base = wlog.size();
    applyStimulus(1, 0, 8'h80, 8'h00);
    applyStimulus(0, 0, 8'h80, 8'h00);
    repeat (20) @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1, 0, 8'h90 + 8'(i), 8'h00);
      applyStimulus(0, 0, 8'h90 + 8'(i), 8'h00);
    end
    checkOutput("ov_flag", 16'(bus_if.overflow), 16'h1);
    waitIdle();
    checkOutput("ov_nwrites", 16'(wlog.size() - base), 16'd5);
    if (wlog.size() == base + 5) begin
      checkOutput("ov_w0", 16'(wlog[base]),     16'h080);
      checkOutput("ov_w1", 16'(wlog[base + 1]), 16'h090);
      checkOutput("ov_w2", 16'(wlog[base + 2]), 16'h091);
      checkOutput("ov_w3", 16'(wlog[base + 3]), 16'h092);
      checkOutput("ov_w4", 16'(wlog[base + 4]), 16'h093);
    end
    checkOutput("ov_sticky", 16'(bus_if.overflow), 16'h1);

    // level held for 100 cycles
    base = wlog.size();
    applyStimulus(0, 1, 8'h00, 8'h55);
    repeat (99) @(negedge clk);
    applyStimulus(0, 0, 8'h00, 8'h55);
    waitIdle();
    checkOutput("lvl_nwrites", 16'(wlog.size() - base), 16'd1);
    if (wlog.size() == base + 1) checkOutput("lvl_entry", 16'(wlog[base]), 16'h155);

    // random traffic
    for (int i = 0; i < 6000; i++) begin
      applyStimulus(logic'($urandom_range(0, 15) == 0), logic'($urandom_range(0, 15) == 0),
                    8'($urandom), 8'($urandom));
    end
    applyStimulus(0, 0, 8'h00, 8'h00);
    waitIdle();

    // reset during the enable pulse
    applyStimulus(1, 0, 8'hA5, 8'h00);
    applyStimulus(0, 0, 8'hA5, 8'h00);
    seen = 0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      #1;
      if (bus_if.lcd_e) begin
        seen = 1;
        break;
      end
    end
    checkOutput("rp_e_seen", 16'(seen), 16'h1);
    #2;
    rst = 0;
    #1;
    checkOutput("rp_e",    16'(bus_if.lcd_e),    16'h0);
    checkOutput("rp_busy", 16'(bus_if.busy),     16'h0);
    checkOutput("rp_ovf",  16'(bus_if.overflow), 16'h0);
    checkOutput("rp_db",   16'(bus_if.lcd_db),   16'h0);
    base = wlog.size();
    @(negedge clk);
    rst = 1;
    repeat (50) @(posedge clk);
    #1;
    checkOutput("rp_nowrite", 16'(wlog.size() - base), 16'd0);
    checkOutput("rp_idle",    16'(bus_if.busy),        16'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
